// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer with architectural HI/LO registers.
// Processes one bit per cycle: shift-add multiply (LSB-first) or restoring divide (MSB-first).
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             pause,
   input  logic             abort,
   output logic             busy,
   output logic             stall,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic [5:0]         cnt_r;
   logic [WIDTH-1:0]   acc_hi_r;
   logic [WIDTH-1:0]   acc_lo_r;
   logic [WIDTH-1:0]   opb_r;
   logic [WIDTH-1:0]   a_orig_r;
   logic               is_div_r;
   logic               qsign_r;
   logic               rsign_r;
   logic               bzero_r;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;

   logic               op_valid_s;
   logic               start_s;
   logic               signed_op_s;
   logic               accept_s;
   logic [WIDTH-1:0]   a_abs_s;
   logic [WIDTH-1:0]   b_abs_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH:0]     div_shift_s;
   logic [WIDTH:0]     div_diff_s;
   logic               div_ge_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   fix_hi_s;
   logic [WIDTH-1:0]   fix_lo_s;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
      return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] x);
      return (~x) + {{(2*WIDTH-1){1'b0}}, 1'b1};
   endfunction

   assign busy    = (state_r != ST_IDLE);
   assign hi      = hi_r;
   assign lo      = lo_r;
   assign stall   = busy & op_valid_s;
   assign rd_data = (op == OP_MFHI) ? hi_r : lo_r;

   // Command decode, operand magnitude conversion and acceptance
   always_comb begin
      op_valid_s  = (op != OP_NOP) && (op <= OP_MFLO);
      start_s     = (op >= OP_MULT) && (op <= OP_DIVU);
      signed_op_s = (op == OP_MULT) || (op == OP_DIV);
      accept_s    = (state_r == ST_IDLE) && op_valid_s && !pause && !abort;
      if (signed_op_s && a[WIDTH-1]) begin
         a_abs_s = neg_w(a);
      end else begin
         a_abs_s = a;
      end
      if (signed_op_s && b[WIDTH-1]) begin
         b_abs_s = neg_w(b);
      end else begin
         b_abs_s = b;
      end
   end

   // One iteration of multiply or divide, plus sign fix-up of the final result
   always_comb begin
      if (acc_lo_r[0]) begin
         mul_sum_s = {1'b0, acc_hi_r} + {1'b0, opb_r};
      end else begin
         mul_sum_s = {1'b0, acc_hi_r};
      end
      div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
      div_diff_s  = div_shift_s - {1'b0, opb_r};
      div_ge_s    = (div_shift_s >= {1'b0, opb_r});

      prod_s = {acc_hi_r, acc_lo_r};
      if (qsign_r) begin
         prod_s = neg_d({acc_hi_r, acc_lo_r});
      end else begin
         prod_s = {acc_hi_r, acc_lo_r};
      end

      if (!is_div_r) begin
         fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
         fix_lo_s = prod_s[WIDTH-1:0];
      end else if (bzero_r) begin
         // divide by zero reports the raw dividend, not its magnitude
         fix_hi_s = a_orig_r;
         fix_lo_s = '1;
      end else begin
         fix_lo_s = qsign_r ? neg_w(acc_lo_r) : acc_lo_r;
         fix_hi_s = rsign_r ? neg_w(acc_hi_r) : acc_hi_r;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && start_s) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_s = ST_IDLE;
            end else if (cnt_r == LAST_CNT) begin
               state_s = ST_FIX;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_FIX:  state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath: operand latch, iteration registers and HI/LO writes
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r    <= 6'd0;
         acc_hi_r <= '0;
         acc_lo_r <= '0;
         opb_r    <= '0;
         a_orig_r <= '0;
         is_div_r <= 1'b0;
         qsign_r  <= 1'b0;
         rsign_r  <= 1'b0;
         bzero_r  <= 1'b0;
         hi_r     <= '0;
         lo_r     <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  case (op)
                     OP_MTHI: hi_r <= a;
                     OP_MTLO: lo_r <= a;
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        cnt_r    <= 6'd0;
                        acc_hi_r <= '0;
                        a_orig_r <= a;
                        is_div_r <= (op == OP_DIV) || (op == OP_DIVU);
                        qsign_r  <= signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rsign_r  <= signed_op_s & a[WIDTH-1];
                        bzero_r  <= (b == '0);
                        // multiply: acc_lo holds the multiplier; divide: the dividend
                        if ((op == OP_DIV) || (op == OP_DIVU)) begin
                           acc_lo_r <= a_abs_s;
                           opb_r    <= b_abs_s;
                        end else begin
                           acc_lo_r <= b_abs_s;
                           opb_r    <= a_abs_s;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ST_RUN: begin
               if (!abort) begin
                  cnt_r <= cnt_r + 6'd1;
                  if (is_div_r) begin
                     if (div_ge_s) begin
                        acc_hi_r <= div_diff_s[WIDTH-1:0];
                        acc_lo_r <= {acc_lo_r[WIDTH-2:0], 1'b1};
                     end else begin
                        acc_hi_r <= div_shift_s[WIDTH-1:0];
                        acc_lo_r <= {acc_lo_r[WIDTH-2:0], 1'b0};
                     end
                  end else begin
                     {acc_hi_r, acc_lo_r} <= {mul_sum_s, acc_lo_r[WIDTH-1:1]};
                  end
               end
            end
            ST_FIX: begin
               if (!abort) begin
                  hi_r <= fix_hi_s;
                  lo_r <= fix_lo_s;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (WIDTH=32) with hand-computed expectations.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        pause;
   logic        abort;
   logic        busy;
   logic        stall;
   logic [31:0] rd_data;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad   = 0;
   int nb;

   muldiv_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .op(op), .a(a), .b(b), .pause(pause), .abort(abort),
      .busy(busy), .stall(stall), .rd_data(rd_data), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // issue a mul/div, then count busy cycles; returns in the first non-busy cycle
   task automatic do_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int n);
      op = o; a = av; b = bv;
      cycle();
      op = 4'd0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         cycle();
      end
   endtask

   initial begin
      rst = 1'b1; op = 4'd0; a = 32'd0; b = 32'd0; pause = 1'b0; abort = 1'b0;
      cycle(); cycle();
      rst = 1'b0;
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_stall", {31'd0, stall}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);

      do_op(4'd1, 32'hFFFF_FFFD, 32'd5, nb);
      chk("mult_busy_cycles", nb, 32'd33);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFF1);

      do_op(4'd2, 32'hFFFF_FFFF, 32'd2, nb);
      chk("multu_hi", hi, 32'h0000_0001);
      chk("multu_lo", lo, 32'hFFFF_FFFE);

      do_op(4'd3, 32'hFFFF_FFF9, 32'd2, nb);
      chk("div_busy_cycles", nb, 32'd33);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);

      do_op(4'd4, 32'd100, 32'd7, nb);
      chk("divu_lo", lo, 32'd14);
      chk("divu_hi", hi, 32'd2);

      do_op(4'd4, 32'h64, 32'd0, nb);
      chk("divu0_lo", lo, 32'hFFFF_FFFF);
      chk("divu0_hi", hi, 32'h64);

      do_op(4'd3, 32'hFFFF_FFF9, 32'd0, nb);
      chk("div0_lo", lo, 32'hFFFF_FFFF);
      chk("div0_hi", hi, 32'hFFFF_FFF9);

      do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
      chk("divovf_lo", lo, 32'h8000_0000);
      chk("divovf_hi", hi, 32'd0);

      // MFLO held from T+1 while a MULT runs
      op = 4'd1; a = 32'd6; b = 32'd7;
      cycle();
      op = 4'd8;
      #1;
      chk("stall_rd_old_lo", rd_data, 32'h8000_0000);
      nb = 0;
      while (stall && nb < 100) begin
         nb++;
         cycle();
      end
      chk("stall_cycles", nb, 32'd33);
      chk("stall_rd_new_lo", rd_data, 32'd42);
      op = 4'd7;
      #1;
      chk("mfhi_rd", rd_data, 32'd0);
      op = 4'd0;

      // MTLO then an aborted MULT
      op = 4'd6; a = 32'h55;
      cycle();
      op = 4'd0;
      chk("mtlo_lo", lo, 32'h55);
      chk("mtlo_busy", {31'd0, busy}, 32'd0);
      op = 4'd1; a = 32'd3; b = 32'd4;
      cycle();
      op = 4'd0;
      repeat (9) cycle();
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      chk("abort_busy_after", {31'd0, busy}, 32'd0);
      repeat (40) cycle();
      chk("abort_lo_kept", lo, 32'h55);
      chk("abort_hi_kept", hi, 32'd0);

      // abort together with an op in IDLE, and pause on MTHI: both ignored
      abort = 1'b1; op = 4'd5; a = 32'hDEAD;
      cycle();
      abort = 1'b0; op = 4'd0;
      chk("abort_idle_hi", hi, 32'd0);
      pause = 1'b1; op = 4'd5; a = 32'h1234;
      cycle();
      pause = 1'b0; op = 4'd0;
      chk("pause_mthi_hi", hi, 32'd0);
      chk("pause_mthi_busy", {31'd0, busy}, 32'd0);

      // rst in the middle of a DIVU
      op = 4'd5; a = 32'hAA;
      cycle();
      op = 4'd0;
      chk("mthi_hi", hi, 32'hAA);
      op = 4'd4; a = 32'd100; b = 32'd7;
      cycle();
      op = 4'd0;
      repeat (4) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_lo", lo, 32'd0);

      // pause held during a MULTU does not stretch it; op 9 acts as NOP
      op = 4'd2; a = 32'h0001_0000; b = 32'h0001_0000;
      cycle();
      pause = 1'b1; op = 4'd9;
      #1;
      chk("op9_no_stall", {31'd0, stall}, 32'd0);
      op = 4'd0;
      nb = 1;
      cycle();
      while (busy && nb < 100) begin
         nb++;
         cycle();
      end
      pause = 1'b0;
      chk("pause_busy_cycles", nb, 32'd33);
      chk("pause_mult_hi", hi, 32'd1);
      chk("pause_mult_lo", lo, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
